// File: rtl/seq_divider_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_32_pkg
// Description : Shared types and constants for the iterative RV32M divider.
//               Holds the operation and FSM state enums, the operand width,
//               the iteration count and small helpers for op decoding and
//               two's-complement negation.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_32_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Negating zero yields zero, so a zero quotient/remainder never turns
    // non-zero when its sign flag is set.
    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return (~v) + XLEN'(1);
    endfunction

endpackage : seq_divider_32_pkg
`default_nettype wire

// File: rtl/seq_divider_32_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_32_if
// Description : Request/response bundle between the EX stage and the divider.
//               master : issues start/op/dividend/divisor/kill, sees busy,
//                        done and result.
//               slave  : the divider itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_32_if;
    import seq_divider_32_pkg::*;

    logic            start;
    div_op_e         op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, kill,
        output busy, done, result
    );

endinterface : seq_divider_32_if
`default_nettype wire

// File: rtl/ADDER_32bits.sv
`default_nettype none
// ============================================================================
// Module      : ADDER_32bits
// Description : 32-bit ripple-style adder with carry in/out. The divider
//               uses it as a subtractor (A + ~B + 1).
// Ports       : i_a, i_b  - addends
//               i_cin     - carry in
//               o_sum     - 32-bit sum
//               o_cout    - carry out (1 => no borrow when subtracting)
// Revision    : 1.0 - initial release
// ============================================================================
module ADDER_32bits (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic        i_cin,
    output wire logic [31:0] o_sum,
    output wire logic        o_cout
);

    wire logic [32:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
    assign o_sum  = w_full[31:0];
    assign o_cout = w_full[32];

endmodule : ADDER_32bits
`default_nettype wire

// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_32
// Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//               One quotient bit per cycle over 32 cycles, then a sign-fix
//               cycle. Divide-by-zero and signed overflow resolve in one
//               cycle without iterating. Operand width is XLEN (32) from the
//               package; the single-adder datapath is fixed at 32 bits.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - seq_divider_32_if.slave
//                      start/op/dividend/divisor : request, sampled when idle
//                      kill   : abort an operation in flight
//                      busy   : high in CALC and FIX
//                      done   : one-cycle result-valid pulse
//                      result : quotient or remainder, held until replaced
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_32 (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_divider_32_if.slave    bus
);
    import seq_divider_32_pkg::*;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    div_state_e      r_state;
    div_op_e         r_op;
    logic [XLEN-1:0] r_dvs;      // |divisor|
    logic [XLEN-1:0] r_q;        // dividend shifting out / quotient shifting in
    logic [XLEN-1:0] r_rem;      // partial remainder
    logic [CNT_W-1:0] r_cnt;
    logic            r_sign_q;
    logic            r_sign_r;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    wire logic            w_idle_like;
    wire logic            w_accept;
    wire logic            w_signed;
    wire logic            w_is_rem;
    wire logic            w_div_zero;
    wire logic            w_overflow;
    wire logic            w_special;
    wire logic [XLEN-1:0] w_special_res;
    wire logic [XLEN-1:0] w_dvd_abs;
    wire logic [XLEN-1:0] w_dvs_abs;

    // A new request may land in the DONE cycle, giving back-to-back issue.
    // kill takes priority over a simultaneous start.
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = bus.start && !bus.kill && w_idle_like;

    assign w_signed    = op_is_signed(bus.op);
    assign w_is_rem    = op_is_rem(bus.op);
    assign w_div_zero  = (bus.divisor == '0);
    assign w_overflow  = w_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                                  && (bus.divisor  == {XLEN{1'b1}});
    assign w_special   = w_div_zero || w_overflow;

    // Divide-by-zero: quotient all ones, remainder = dividend.
    // Overflow: quotient = dividend (0x8000_0000), remainder = 0.
    assign w_special_res = w_div_zero ? (w_is_rem ? bus.dividend : {XLEN{1'b1}})
                                      : (w_is_rem ? '0 : bus.dividend);

    assign w_dvd_abs = (w_signed && bus.dividend[XLEN-1]) ? twos_neg(bus.dividend) : bus.dividend;
    assign w_dvs_abs = (w_signed && bus.divisor[XLEN-1])  ? twos_neg(bus.divisor)  : bus.divisor;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // The shifted remainder needs 33 bits, but its top bit exists only
    // combinationally: after each restoring step the stored remainder is
    // below the divisor and so always fits in 32 bits.
    wire logic [XLEN:0]   w_rem_sh;
    wire logic [XLEN-1:0] w_q_sh;
    wire logic [XLEN-1:0] w_diff;
    wire logic            w_cout;
    wire logic            w_take;

    assign w_rem_sh = {r_rem, r_q[XLEN-1]};
    assign w_q_sh   = {r_q[XLEN-2:0], 1'b0};

    ADDER_32bits u_sub (
        .i_a    (w_rem_sh[XLEN-1:0]),
        .i_b    (~r_dvs),
        .i_cin  (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_cout)
    );

    // Subtraction succeeds if the 33-bit shifted remainder overflowed 32 bits
    // (it is then certainly >= divisor) or the 32-bit subtract did not borrow.
    assign w_take = w_rem_sh[XLEN] | w_cout;

    wire logic [XLEN-1:0] w_q_fix;
    wire logic [XLEN-1:0] w_r_fix;

    assign w_q_fix = r_sign_q ? twos_neg(r_q)   : r_q;
    assign w_r_fix = r_sign_r ? twos_neg(r_rem) : r_rem;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_DIV;
            r_dvs    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op     <= bus.op;
                        r_dvs    <= w_dvs_abs;
                        r_q      <= w_dvd_abs;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_sign_q <= w_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                        r_sign_r <= w_signed && bus.dividend[XLEN-1];
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_CALC: begin
                    if (bus.kill) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_take ? w_diff : w_rem_sh[XLEN-1:0];
                        r_q   <= {w_q_sh[XLEN-1:1], w_take};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end

                S_FIX: begin
                    if (bus.kill) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= op_is_rem(r_op) ? w_r_fix : w_q_fix;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule : seq_divider_32
`default_nettype wire
